// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and shared memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              err;

    // Arbiter side: takes requests and memory responses, drives the memory port and acks.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    // Environment side: requesters plus the memory itself.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one memory port; MEM_ARB_TIMEOUT_EN adds busy timeout abort
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;
    logic [3:0]        starve_q, starve_d;

    logic              if_elig, d_elig;
    logic              grant_if, grant_d, done, abort;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0]           tmo_q, tmo_d;
`endif

    // State register and all registered outputs; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            starve_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Next state: data beats fetch unless fetch has waited out STARVE_LIMIT data grants.
    always_comb begin
        if_elig  = bus.if_req && !if_ack_q;
        d_elig   = bus.d_req && !d_ack_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        state_d  = state_q;
        case (state_q)
            IDLE: begin
                if (if_elig && (!d_elig || starve_q == LIMIT)) begin
                    grant_if = 1'b1;
                    state_d  = BUSY_IF;
                end else if (d_elig) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (bus.mem_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath: capture the winner at grant, hold the port while busy, ack on completion.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        starve_d    = starve_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        if (grant_if) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
        end
        if (grant_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            if (bus.if_req && starve_q != LIMIT) begin
                starve_d = starve_q + 4'd1;
            end
        end
        if (done || abort) begin
            mem_req_d = 1'b0;
            err_d     = abort;
            if (state_q == BUSY_IF) begin
                if_ack_d   = 1'b1;
                if_rdata_d = abort ? '0 : bus.mem_rdata;
            end else begin
                d_ack_d = 1'b1;
                if (abort) begin
                    d_rdata_d = '0;
                end else if (!mem_we_q) begin
                    d_rdata_d = bus.mem_rdata;
                end
            end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d = tmo_q;
        if (grant_if || grant_d || done || abort) begin
            tmo_d = '0;
        end else if (state_q != IDLE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
`endif
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int STARVE = 4;
    localparam int TMO    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(STARVE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one transfer in flight at most, described by who owns it and what it carries.
    bit          m_busy, m_owner_d, m_we, m_if_ack, m_d_ack, m_err;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    int          m_wait, m_starve;
    int          ack_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner_d = 0; m_we = 0; m_if_ack = 0; m_d_ack = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
        m_wait = 0; m_starve = 0;
    endtask

    // Advance the model by one rising edge using the inputs the DUT sees at that edge.
    task automatic model_step();
        bit if_ok, d_ok, fin, abt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if_ok = bus.if_req && !m_if_ack;
        d_ok  = bus.d_req && !m_d_ack;
        m_if_ack = 0; m_d_ack = 0; m_err = 0;
        if (m_busy) begin
            fin = bus.mem_ready;
            abt = 0;
            if (!fin) begin
                m_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
                abt = (m_wait >= TMO);
`endif
            end
            if (fin || abt) begin
                m_busy = 0;
                m_err  = abt;
                if (m_owner_d) begin
                    m_d_ack = 1;
                    if (abt) m_d_rdata = '0;
                    else if (!m_we) m_d_rdata = bus.mem_rdata;
                end else begin
                    m_if_ack   = 1;
                    m_if_rdata = abt ? 32'h0 : bus.mem_rdata;
                end
            end
        end else if (if_ok && (!d_ok || m_starve == STARVE)) begin
            m_busy = 1; m_owner_d = 0; m_we = 0;
            m_addr = bus.if_addr; m_wdata = '0; m_wait = 0; m_starve = 0;
        end else if (d_ok) begin
            m_busy = 1; m_owner_d = 1; m_we = bus.d_we;
            m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_wait = 0;
            if (bus.if_req && m_starve < STARVE) m_starve++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    function automatic logic [31:0] pack_acks(input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++)
            w = {w[27:0], (k < ack_log.size()) ? 4'(ack_log[k]) : 4'h0};
        return w;
    endfunction

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk_b("mem_req", bus.mem_req, m_busy);
        chk_b("if_ack", bus.if_ack, m_if_ack);
        chk_b("d_ack", bus.d_ack, m_d_ack);
        chk_b("err", bus.err, m_err);
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("d_rdata", bus.d_rdata, m_d_rdata);
        chk_b("ack_exclusive", bus.if_ack & bus.d_ack, 1'b0);
        if (m_busy || !rst_n) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk_b("mem_we", bus.mem_we, m_we);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
        if (bus.d_ack) ack_log.push_back(13);
        if (bus.if_ack) ack_log.push_back(15);
    end

    task automatic clear_inputs();
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #1 rst_n = 0;
        tick();
        tick();
        chk_b("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        rst_n = 1;
        tick();

        // Fetch only: address 0x10, memory answers one cycle after mem_req.
        bus.if_req = 1; bus.if_addr = 32'h10;
        tick();
        chk_b("f_mem_req", bus.mem_req, 1'b1);
        chk("f_mem_addr", bus.mem_addr, 32'h10);
        chk_b("f_mem_we", bus.mem_we, 1'b0);
        bus.if_req = 0; bus.if_addr = 32'hFFFF_FFF0;
        bus.mem_ready = 1; bus.mem_rdata = 32'h0050_0093;
        tick();
        chk_b("f_if_ack", bus.if_ack, 1'b1);
        chk("f_if_rdata", bus.if_rdata, 32'h0050_0093);
        chk_b("f_mem_req_drop", bus.mem_req, 1'b0);
        bus.mem_ready = 0; bus.mem_rdata = 32'h1234_5678;
        tick();
        chk_b("f_if_ack_once", bus.if_ack, 1'b0);
        chk("f_if_rdata_hold", bus.if_rdata, 32'h0050_0093);

        // Store with delayed ready; request inputs change while busy and must not matter.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 32'h44; bus.d_wdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            chk("s_mem_addr", bus.mem_addr, 32'h40);
            chk_b("s_mem_we", bus.mem_we, 1'b1);
            chk("s_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            if (k == 2) bus.mem_ready = 1;
            tick();
        end
        chk_b("s_d_ack", bus.d_ack, 1'b1);
        chk("s_d_rdata_kept", bus.d_rdata, 32'h0);
        bus.mem_ready = 0;
        tick();
        chk_b("s_d_ack_once", bus.d_ack, 1'b0);

        // Simultaneous requests: data first, then fetch.
        ack_log.delete();
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        bus.mem_ready = 1; bus.mem_rdata = 32'hA5A5_0001;
        for (int k = 0; k < 6; k++) tick();
        bus.if_req = 0; bus.d_req = 0;
        tick();
        tick();
        chk("both_order", pack_acks(2), 32'h0000_00DF);

        // Starvation: fetch present at every data grant, loses four times then wins.
        pulse_reset();
        ack_log.delete();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h280; bus.if_addr = 32'h180;
        bus.mem_ready = 1;
        for (int p = 0; p < 5; p++) begin
            bus.if_req = 1;
            tick();
            bus.if_req = 0;
            tick();
            tick();
        end
        bus.d_req = 0;
        tick();
        tick();
        chk("starve_order", pack_acks(5), 32'h000D_DDDF);

        // Reset while a load is busy; pending fetch is served right after release.
        clear_inputs();
        bus.d_req = 1; bus.d_addr = 32'h300;
        tick();
        bus.d_req = 0; bus.if_req = 1; bus.if_addr = 32'h80;
        tick();
        rst_n = 0;
        model_reset();
        #1;
        chk_b("r_mem_req_now", bus.mem_req, 1'b0);
        chk_b("r_d_ack_now", bus.d_ack, 1'b0);
        tick();
        rst_n = 1;
        tick();
        chk_b("r_fetch_grant", bus.mem_req, 1'b1);
        chk("r_fetch_addr", bus.mem_addr, 32'h80);
        bus.if_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        chk_b("r_if_ack", bus.if_ack, 1'b1);
        bus.mem_ready = 0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: fetch is aborted after TMO busy cycles.
        bus.if_req = 1; bus.if_addr = 32'h500; bus.mem_ready = 0;
        tick();
        bus.if_req = 0;
        for (int k = 0; k < TMO - 1; k++) begin
            tick();
            chk_b("t_no_ack_yet", bus.if_ack, 1'b0);
        end
        tick();
        chk_b("t_if_ack", bus.if_ack, 1'b1);
        chk_b("t_err", bus.err, 1'b1);
        chk("t_if_rdata", bus.if_rdata, 32'h0);
        chk_b("t_mem_req", bus.mem_req, 1'b0);
        tick();
`endif

        // Randomized traffic, including stray mem_ready while idle and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                model_reset();
            end else begin
                rst_n = 1;
            end
            bus.if_req    = ($urandom_range(0, 99) < 55);
            bus.if_addr   = $urandom;
            bus.d_req     = ($urandom_range(0, 99) < 60);
            bus.d_we      = 1'($urandom_range(0, 1));
            bus.d_addr    = $urandom;
            bus.d_wdata   = $urandom;
            bus.mem_ready = ($urandom_range(0, 99) < 45);
            bus.mem_rdata = $urandom;
            tick();
        end
        rst_n = 1;
        clear_inputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
